// File: rtl/drawrect_burst.sv
// Rectangle draw engine: clips a latched rectangle and streams it to the SDRAM write port as bursts.
// Build option: define DRAWRECT_CLIP_EN to clip at the screen edges; otherwise out-of-bounds rectangles are rejected.
module drawrect_burst #(
    parameter int BURST_BITS          = 10,
    parameter int SCREEN_WIDTH        = 640,
    parameter int SCREEN_HEIGHT       = 480,
    parameter int MAX_WRITE_BURST_LEN = 128,
    parameter int BIT_SIZE            = 10,
    parameter int ADDR_BITS           = 22,
    parameter int FB_BASE             = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  mode,
    input  logic [BIT_SIZE-1:0]   x_pixel,
    input  logic [BIT_SIZE-1:0]   y_pixel,
    input  logic [BIT_SIZE-1:0]   width,
    input  logic [BIT_SIZE-1:0]   height,
    input  logic [15:0]           color,
    input  logic                  write_burst_data_req,
    input  logic                  write_burst_data_finish,
    output logic                  write_burst_req,
    output logic [BURST_BITS-1:0] write_burst_len,
    output logic [ADDR_BITS-1:0]  addr,
    output logic [15:0]           rgb,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int CW = BIT_SIZE + 1;
    localparam logic [CW-1:0] SW_C  = CW'(SCREEN_WIDTH);
    localparam logic [CW-1:0] SH_C  = CW'(SCREEN_HEIGHT);
    localparam logic [CW-1:0] ONE_C = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [BIT_SIZE-1:0] ZERO_C = {BIT_SIZE{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_REQ   = 3'd2,
        S_DATA  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state_r, state_nx;

    logic [BIT_SIZE-1:0] x_r, y_r, w_r, h_r;
    logic                mode_r;
    logic [CW-1:0]       row_r, col_r, seg_end_r;
    logic                seg_r;

    logic [CW-1:0] x_s, y_s, x_sum_s, y_sum_s, x_end_s, y_end_s;
    logic [CW-1:0] bot_row_s, right_col_s, adv_col_s;
    logic          empty_s, reject_s, right_ok_s;

    logic [CW-1:0]         nrow_s, ncol_s, nend_s, rem_s;
    logic                  nseg_s, last_s;
    logic [BURST_BITS-1:0] nlen_s;
    logic [ADDR_BITS-1:0]  naddr_s;

    logic accept_s, load_s;

    // Edge rows draw the whole clipped span; fill mode treats every row as an edge row.
    function automatic logic row_is_edge(input logic m, input logic [CW-1:0] row,
                                         input logic [CW-1:0] top, input logic [CW-1:0] bot);
        return (!m) || (row == top) || (row == bot);
    endfunction

    // Clip limits and rectangle classification, one bit wider than the inputs so sums never wrap
    always_comb begin
        x_s         = CW'(x_r);
        y_s         = CW'(y_r);
        x_sum_s     = x_s + CW'(w_r);
        y_sum_s     = y_s + CW'(h_r);
        x_end_s     = (x_sum_s > SW_C) ? SW_C : x_sum_s;
        y_end_s     = (y_sum_s > SH_C) ? SH_C : y_sum_s;
        bot_row_s   = y_sum_s - ONE_C;
        right_col_s = x_sum_s - ONE_C;
        right_ok_s  = (right_col_s < x_end_s) && (right_col_s != x_s);
        empty_s     = (w_r == ZERO_C) || (h_r == ZERO_C) || (x_s >= SW_C) || (y_s >= SH_C);
`ifdef DRAWRECT_CLIP_EN
        reject_s    = 1'b0;
`else
        reject_s    = (x_sum_s > SW_C) || (y_sum_s > SH_C);
`endif
    end

    // Next burst position: first segment in SETUP, otherwise the step after the current burst
    always_comb begin
        adv_col_s = col_r + CW'(write_burst_len);
        last_s    = 1'b0;
        if (state_r == S_SETUP) begin
            nrow_s = y_s;
            ncol_s = x_s;
            nend_s = x_end_s;
            nseg_s = 1'b0;
        end else if (adv_col_s < seg_end_r) begin
            nrow_s = row_r;
            ncol_s = adv_col_s;
            nend_s = seg_end_r;
            nseg_s = seg_r;
        end else if (!seg_r && !row_is_edge(mode_r, row_r, y_s, bot_row_s) && right_ok_s) begin
            nrow_s = row_r;
            ncol_s = right_col_s;
            nend_s = right_col_s + ONE_C;
            nseg_s = 1'b1;
        end else begin
            nrow_s = row_r + ONE_C;
            ncol_s = x_s;
            nend_s = row_is_edge(mode_r, nrow_s, y_s, bot_row_s) ? x_end_s : (x_s + ONE_C);
            nseg_s = 1'b0;
            last_s = (nrow_s >= y_end_s);
        end
        rem_s = nend_s - ncol_s;
        if (32'(rem_s) > 32'(MAX_WRITE_BURST_LEN)) begin
            nlen_s = BURST_BITS'(MAX_WRITE_BURST_LEN);
        end else begin
            nlen_s = BURST_BITS'(rem_s);
        end
        naddr_s = ADDR_BITS'(FB_BASE) + ADDR_BITS'(nrow_s) * ADDR_BITS'(SCREEN_WIDTH)
                + ADDR_BITS'(ncol_s);
    end

    // Control FSM next state; a finish seen in REQ closes the burst just like one seen in DATA
    always_comb begin
        state_nx = state_r;
        accept_s = 1'b0;
        load_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
                    state_nx = S_SETUP;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_SETUP: begin
                if (reject_s || empty_s) begin
                    state_nx = S_DONE;
                end else begin
                    load_s   = 1'b1;
                    state_nx = S_REQ;
                end
            end
            S_REQ, S_DATA: begin
                if (write_burst_data_finish) begin
                    if (last_s) begin
                        state_nx = S_DONE;
                    end else begin
                        load_s   = 1'b1;
                        state_nx = S_REQ;
                    end
                end else if (state_r == S_REQ && write_burst_data_req) begin
                    state_nx = S_DATA;
                end else begin
                    state_nx = state_r;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // State, command latch, burst registers and registered handshake outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r         <= S_IDLE;
            x_r             <= ZERO_C;
            y_r             <= ZERO_C;
            w_r             <= ZERO_C;
            h_r             <= ZERO_C;
            mode_r          <= 1'b0;
            row_r           <= {CW{1'b0}};
            col_r           <= {CW{1'b0}};
            seg_end_r       <= {CW{1'b0}};
            seg_r           <= 1'b0;
            write_burst_req <= 1'b0;
            write_burst_len <= {BURST_BITS{1'b0}};
            addr            <= {ADDR_BITS{1'b0}};
            rgb             <= 16'h0000;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
        end else begin
            state_r <= state_nx;
            if (accept_s) begin
                x_r    <= x_pixel;
                y_r    <= y_pixel;
                w_r    <= width;
                h_r    <= height;
                mode_r <= mode;
                rgb    <= color;
                error  <= 1'b0;
            end else if (state_r == S_SETUP && reject_s) begin
                error <= 1'b1;
            end
            if (load_s) begin
                row_r           <= nrow_s;
                col_r           <= ncol_s;
                seg_end_r       <= nend_s;
                seg_r           <= nseg_s;
                write_burst_len <= nlen_s;
                addr            <= naddr_s;
            end
            write_burst_req <= (state_nx == S_REQ);
            busy            <= (state_nx == S_SETUP) || (state_nx == S_REQ) || (state_nx == S_DATA);
            done            <= (state_nx == S_DONE);
        end
    end

endmodule
